hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised scoreboard-based hazard unit for the pipelined core; it replaces the combinational destination-compare hazard detector. Each architectural register has a countdown counter giving the cycles until its pending result can be consumed. The unit decodes source registers from the decode-stage instruction, stalls on RAW and WAW hazards, inserts bubbles on stall or flush, and keeps a saturating stall-cycle statistic. It sits between the IF/ID register and the ID/EX register and drives the PC enable, the IF/ID enable and the ID/EX bubble select.

## Interface
- INST_W, 16: instruction width; opcode is inst[INST_W-1:INST_W-4]
- REG_AW, 3: register address width; 2**REG_AW registers, register 0 never tracked
- MAX_LAT, 4: largest legal id_lat value; counter width is clog2(MAX_LAT+1)
- STAT_W, 16: width of the stall statistic counter
- clk  in  1: clock; all state updates on the rising edge
- rst  in  1: synchronous, active-high reset
- inst  in  INST_W: decode-stage instruction
- id_valid  in  1: decode-stage instruction is real (not a bubble)
- id_rd  in  REG_AW: destination register of the decode-stage instruction
- id_wb_en  in  1: decode-stage instruction writes id_rd
- id_lat  in  clog2(MAX_LAT+1): stall cycles a dependent instruction needs; 0 means fully forwarded and not tracked
- ex_flush  in  1: execute stage redirects control flow (taken branch/jump, opcode 4'b1111 in EX)
- pc_en  out  1: PC register load enable
- if_id_en  out  1: IF/ID register load enable
- id_ex_regs_sel  out  1: 1 loads a bubble into ID/EX
- busy  out  1: at least one counter is nonzero
- stall_cnt  out  STAT_W: saturating count of stall cycles

## Operation
- Source decode on op = inst[INST_W-1:INST_W-4]:
  - rs1 = inst[8:6] when op <= 9 or op == 12; inst[11:9] when op == 11; otherwise 0.
  - rs2 = inst[5:3] when op <= 8; inst[8:6] when op == 10 or op == 11; otherwise 0.
- Scoreboard: cnt[r] for r = 1 .. 2**REG_AW-1. cnt[0] is hardwired to 0.
- raw = (rs1 != 0 && cnt[rs1] != 0) || (rs2 != 0 && cnt[rs2] != 0).
- waw = id_wb_en && id_rd != 0 && id_lat != 0 && cnt[id_rd] >= id_lat. This prevents a younger write from becoming ready before, or at the same time as, an older one.
- stall = id_valid && !ex_flush && (raw || waw).
- issue = id_valid && !ex_flush && !stall.
- Outputs:
  - pc_en = if_id_en = !stall.
  - id_ex_regs_sel = stall || ex_flush || !id_valid.
- Counter update, every cycle and for every r:
  - If issue && id_wb_en && id_rd == r && r != 0 && id_lat != 0: cnt[r] <= id_lat.
  - Otherwise, if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - When the same register is both set and decremented in one cycle, the set wins.
- Flush: the decode instruction is killed and never sets the scoreboard. Instructions already issued keep counting down, because their writes still retire.
- Statistic: stall_cnt increments in every cycle where stall = 1 and holds at 2**STAT_W-1.
- id_lat > MAX_LAT is illegal input. The result is undefined; the assertion in the bench flags it.

## Timing
- Outputs pc_en, if_id_en, id_ex_regs_sel and busy are combinational from the inputs and current state, with no added latency. stall_cnt is registered.
- A producer issued in cycle t with id_lat = L has cnt = L in cycle t+1 and cnt = 0 in cycle t+L+1.
  - A dependent instruction held in decode from t+1 stalls exactly L cycles and issues in t+L+1.
- Reset (rst high at an edge):
  - All cnt clear to 0 and stall_cnt clears to 0.
  - In the cycle after the reset edge, with id_valid = 0: pc_en = 1, if_id_en = 1, id_ex_regs_sel = 1, busy = 0.
  - Reset asserted mid-stall clears all pending hazards immediately; the held instruction issues in the first cycle after reset is released.
- ex_flush has priority over stall. In a flush cycle pc_en = 1 and if_id_en = 1 so the redirected fetch loads, and id_ex_regs_sel = 1.

## Test plan
- Reset, then id_valid = 0 -> pc_en = 1, if_id_en = 1, id_ex_regs_sel = 1, busy = 0, stall_cnt = 0.
- RAW stall:
  - Stimulus: issue a write to r3 with id_lat = 2, then an op-0 instruction with inst[8:6] = 3.
  - Required: exactly 2 cycles with pc_en = 0 and id_ex_regs_sel = 1, then the instruction issues; stall_cnt = 2.
- Register 0 and zero latency:
  - Stimulus: a write to r0 with id_lat = 3, then a reader of r0; separately, a write to r5 with id_lat = 0, then a reader of r5.
  - Required: no stall in either case, and busy = 0 throughout.
- WAW:
  - Stimulus: r4 written with id_lat = 4; next cycle, another write to r4 with id_lat = 2 (cnt[r4] = 4 >= 2).
  - Required: the second write stalls until cnt[r4] = 1, then issues and sets cnt[r4] = 2.
- Flush:
  - Stimulus: ex_flush = 1 while decode holds a stalled reader of a pending r2.
  - Required: pc_en = 1 and id_ex_regs_sel = 1; the killed write does not set the scoreboard; the r2 counter keeps decrementing.
- Saturation and reset mid-operation:
  - Stimulus: force stalls with STAT_W = 4.
  - Required: stall_cnt stops at 15.
  - Stimulus: assert rst while a counter holds 3.
  - Required: next cycle cnt = 0, busy = 0, no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdown of cycles until a pending
// result is consumable; stalls decode on RAW/WAW, bubbles ID/EX on stall or flush.
module hazard_scoreboard #(
    parameter int INST_W  = 16,
    parameter int REG_AW  = 3,
    parameter int MAX_LAT = 4,
    parameter int STAT_W  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INST_W-1:0]                inst,
    input  logic                             id_valid,
    input  logic [REG_AW-1:0]                id_rd,
    input  logic                             id_wb_en,
    input  logic [$clog2(MAX_LAT+1)-1:0]     id_lat,
    input  logic                             ex_flush,
    output logic                             pc_en,
    output logic                             if_id_en,
    output logic                             id_ex_regs_sel,
    output logic                             busy,
    output logic [STAT_W-1:0]                stall_cnt
);

    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam int NREG  = 2 ** REG_AW;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0]  cnt [NREG];
    logic [3:0]        op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              raw;
    logic              waw;
    logic              stall;
    logic              issue;
    logic              unused_inst;

    assign op          = inst[INST_W-1 -: 4];
    assign unused_inst = ^inst[2:0];

    always_comb begin
        rs1 = '0;
        rs2 = '0;
        if (op <= 4'd9 || op == 4'd12)
            rs1 = inst[6 +: REG_AW];
        else if (op == 4'd11)
            rs1 = inst[9 +: REG_AW];
        if (op <= 4'd8)
            rs2 = inst[3 +: REG_AW];
        else if (op == 4'd10 || op == 4'd11)
            rs2 = inst[6 +: REG_AW];
    end

    // A younger write must not become ready at or before an older one to the same register.
    assign raw   = (rs1 != '0 && cnt[rs1] != '0) || (rs2 != '0 && cnt[rs2] != '0);
    assign waw   = id_wb_en && id_rd != '0 && id_lat != '0 && cnt[id_rd] >= id_lat;
    assign stall = id_valid && !ex_flush && (raw || waw);
    assign issue = id_valid && !ex_flush && !stall;

    assign pc_en          = !stall;
    assign if_id_en       = !stall;
    assign id_ex_regs_sel = stall || ex_flush || !id_valid;

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREG; r++)
            if (cnt[r] != '0)
                busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)
                    cnt[r] <= '0;
                else if (issue && id_wb_en && id_rd == REG_AW'(r) && id_lat != '0)
                    cnt[r] <= id_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (STAT_W = 4 to reach saturation).
module tb_hazard_scoreboard;

    localparam int STAT_W = 4;

    logic        clk;
    logic        rst;
    logic [15:0] inst;
    logic        id_valid;
    logic [2:0]  id_rd;
    logic        id_wb_en;
    logic [2:0]  id_lat;
    logic        ex_flush;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_regs_sel;
    logic        busy;
    logic [STAT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .INST_W (16),
        .REG_AW (3),
        .MAX_LAT(4),
        .STAT_W (STAT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst          (inst),
        .id_valid      (id_valid),
        .id_rd         (id_rd),
        .id_wb_en      (id_wb_en),
        .id_lat        (id_lat),
        .ex_flush      (ex_flush),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_regs_sel(id_ex_regs_sel),
        .busy          (busy),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && id_valid && id_wb_en)
            assert (id_lat <= 3'd4) else $error("illegal id_lat %0d", id_lat);

    typedef struct {
        logic        rst;
        logic        chk;
        logic        valid;
        logic [15:0] inst;
        logic [2:0]  rd;
        logic        wb;
        logic [2:0]  lat;
        logic        flush;
        logic        e_pc;
        logic        e_sel;
        logic        e_busy;
        logic [3:0]  e_sc;
    } vec_t;

    vec_t vecs[$];

    localparam logic [15:0] WR = 16'hD000;  // op 13: no source registers

    function automatic logic [15:0] rd_of(input logic [2:0] r);
        return {4'h0, 3'b000, r, 6'b000000};
    endfunction

    task automatic add(input logic r, input logic c, input logic v, input logic [15:0] in,
                       input logic [2:0] d, input logic w, input logic [2:0] l, input logic f,
                       input logic pc, input logic sel, input logic b, input logic [3:0] sc);
        vec_t t;
        t.rst = r; t.chk = c; t.valid = v; t.inst = in; t.rd = d; t.wb = w; t.lat = l;
        t.flush = f; t.e_pc = pc; t.e_sel = sel; t.e_busy = b; t.e_sc = sc;
        vecs.push_back(t);
    endtask

    task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.valid; inst = t.inst; id_rd = t.rd;
        id_wb_en = t.wb; id_lat = t.lat; ex_flush = t.flush;
    endtask

    initial begin
        int n;
        vec_t t;
        rst = 1'b1; inst = '0; id_valid = 1'b0; id_rd = '0; id_wb_en = 1'b0;
        id_lat = '0; ex_flush = 1'b0;

        //   rst chk v  inst       rd  wb lat fl  pc sel busy sc
        add(1, 0, 0, 16'h0,     0, 0, 0, 0,  1, 1, 0, 0);   // reset
        add(0, 1, 0, 16'h0,     0, 0, 0, 0,  1, 1, 0, 0);   // idle after reset
        add(0, 1, 1, WR,        3, 1, 2, 0,  1, 0, 0, 0);   // RAW producer r3 lat2
        add(0, 1, 1, rd_of(3),  0, 0, 0, 0,  0, 1, 1, 0);
        add(0, 1, 1, rd_of(3),  0, 0, 0, 0,  0, 1, 1, 1);
        add(0, 1, 1, rd_of(3),  0, 0, 0, 0,  1, 0, 0, 2);
        add(0, 1, 1, WR,        0, 1, 3, 0,  1, 0, 0, 2);   // r0 never tracked
        add(0, 1, 1, rd_of(0),  0, 0, 0, 0,  1, 0, 0, 2);
        add(0, 1, 1, WR,        5, 1, 0, 0,  1, 0, 0, 2);   // lat 0 not tracked
        add(0, 1, 1, rd_of(5),  0, 0, 0, 0,  1, 0, 0, 2);
        add(0, 1, 1, WR,        4, 1, 4, 0,  1, 0, 0, 2);   // WAW: r4 lat4
        add(0, 1, 1, WR,        4, 1, 2, 0,  0, 1, 1, 2);
        add(0, 1, 1, WR,        4, 1, 2, 0,  0, 1, 1, 3);
        add(0, 1, 1, WR,        4, 1, 2, 0,  0, 1, 1, 4);
        add(0, 1, 1, WR,        4, 1, 2, 0,  1, 0, 1, 5);   // cnt=1 < 2: issues, sets 2
        add(0, 1, 1, rd_of(4),  0, 0, 0, 0,  0, 1, 1, 5);
        add(0, 1, 1, rd_of(4),  0, 0, 0, 0,  0, 1, 1, 6);
        add(0, 1, 1, rd_of(4),  0, 0, 0, 0,  1, 0, 0, 7);
        add(0, 1, 1, WR,        2, 1, 3, 0,  1, 0, 0, 7);   // flush: r2 lat3
        add(0, 1, 1, rd_of(2),  6, 1, 4, 0,  0, 1, 1, 7);
        add(0, 1, 1, rd_of(2),  6, 1, 4, 1,  1, 1, 1, 8);   // killed, r6 not set
        add(0, 1, 0, 16'h0,     0, 0, 0, 0,  1, 1, 1, 8);
        add(0, 1, 0, 16'h0,     0, 0, 0, 0,  1, 1, 0, 8);
        add(0, 1, 1, WR,        7, 1, 4, 0,  1, 0, 0, 8);   // saturation
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, rd_of(7), 0, 0, 0, 0,  0, 1, 1, 4'(8 + i));
        add(0, 1, 1, WR,        7, 1, 4, 0,  1, 0, 0, 12);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, rd_of(7), 0, 0, 0, 0,  0, 1, 1, 4'(12 + i));
        add(0, 1, 0, 16'h0,     0, 0, 0, 0,  1, 1, 0, 15);  // held at 15
        add(0, 1, 1, WR,        1, 1, 4, 0,  1, 0, 0, 15);  // reset mid-stall
        add(0, 1, 1, rd_of(1),  0, 0, 0, 0,  0, 1, 1, 15);
        add(1, 0, 1, rd_of(1),  0, 0, 0, 0,  0, 1, 1, 15);  // cnt[1] = 3 here
        add(0, 1, 1, rd_of(1),  0, 0, 0, 0,  1, 0, 0, 0);
        add(0, 1, 0, 16'h0,     0, 0, 0, 0,  1, 1, 0, 0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                cmp("pc_en",          i, 16'(pc_en),          16'(vecs[i].e_pc));
                cmp("if_id_en",       i, 16'(if_id_en),       16'(vecs[i].e_pc));
                cmp("id_ex_regs_sel", i, 16'(id_ex_regs_sel), 16'(vecs[i].e_sel));
                cmp("busy",           i, 16'(busy),           16'(vecs[i].e_busy));
                cmp("stall_cnt",      i, 16'(stall_cnt),      16'(vecs[i].e_sc));
            end
        end

        // Hand sequence: producer at MAX_LAT, dependent stalls exactly 4 cycles.
        t = vecs[0];
        t.rst = 0; t.valid = 1; t.inst = WR; t.rd = 3; t.wb = 1; t.lat = 4; t.flush = 0;
        @(posedge clk); #1; drive(t);
        @(negedge clk);
        cmp("lat4_producer_issue", 100, 16'(pc_en), 16'd1);
        t.inst = rd_of(3); t.rd = 0; t.wb = 0; t.lat = 0;
        @(posedge clk); #1; drive(t);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pc_en) break;
            n++;
            @(posedge clk); #1;
        end
        cmp("lat4_stall_cycles", 101, 16'(n), 16'd4);
        cmp("lat4_stall_cnt",    102, 16'(stall_cnt), 16'd4);
        cmp("lat4_issue_sel",    103, 16'(id_ex_regs_sel), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
